// File: rtl/optflow_pkg.sv
// optflow_pkg
//   Shared types and default sizing for the optical-flow refinement control
//   blocks.
//   - warp_ctrl_state_e : iteration sequencer states. IDLE is encoded as 0, so
//                         a cleared state register reads as IDLE.
//   - DEF_*             : default parameter values for warp_iter_ctrl and
//                         watchdog_timer.
package optflow_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FLOW_GO   = 3'd1,
    FLOW_WAIT = 3'd2,
    WARP_GO   = 3'd3,
    WARP_WAIT = 3'd4,
    SWAP      = 3'd5,
    FINISH    = 3'd6
  } warp_ctrl_state_e;

  localparam int DEF_MAX_ITERS      = 8;
  localparam int DEF_ITER_WIDTH     = 4;
  // A full 160x120 warp takes about 160*120*14 cycles, so this leaves headroom.
  localparam int DEF_TIMEOUT_CYCLES = 1000000;
  localparam int DEF_TMR_WIDTH      = 20;

endpackage

// File: rtl/watchdog_timer.sv
// watchdog_timer
//   Per-stage cycle counter. It counts while en is high and flags expiry on the
//   cycle in which the count reaches TIMEOUT_CYCLES-1. A stage that is still
//   waiting therefore gets TIMEOUT_CYCLES wait cycles before it is declared dead.
// Ports
//   clk     in  system clock
//   rst     in  synchronous active-high reset (count -> 0)
//   clr     in  restart the count from 0 (issued when a stage is launched)
//   en      in  count this cycle (high while a stage is awaited)
//   expired out high on the final permitted wait cycle (combinational from count)
module watchdog_timer
  import optflow_pkg::*;
#(
  parameter int TMR_WIDTH      = DEF_TMR_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TMR_WIDTH-1:0] LIMIT = TMR_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [TMR_WIDTH-1:0] count;

  // Expiry is qualified with en so that a count left over in idle states
  // never reaches the controller.
  assign expired = en && (count == LIMIT);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/warp_iter_ctrl.sv
// warp_iter_ctrl
//   Sequences iterative flow refinement. Each iteration launches the flow
//   estimator, waits for it to finish, launches frame_warper, waits for it to
//   finish, and then flips the ping-pong bank select. This repeats for
//   min(num_iters, MAX_ITERS) iterations. A watchdog guards each wait, and an
//   abort input cancels the run.
// Ports
//   clk, rst     clock and synchronous active-high reset
//   start        run request; acted on only in IDLE
//   abort        cancel the run from any state (takes priority over everything)
//   num_iters    iteration count, latched when a start is accepted
//   busy         run in progress
//   done         1-cycle pulse at the end of a run (normal or watchdog)
//   error        sticky watchdog flag, cleared by the next accepted start
//   iter_count   iterations completed in the current or last run
//   buf_sel      ping-pong bank. Engines read bank buf_sel and warp writes ~buf_sel.
//   flow_start   1-cycle launch pulse to the flow estimator
//   flow_done    flow estimator completion pulse
//   warp_start   1-cycle launch pulse to frame_warper
//   warp_done    frame_warper completion pulse
//   state_dbg    current sequencer state (warp_ctrl_state_e encoding)
//
// Handshake: every launch and completion signal is a single-cycle pulse with
// no back-pressure. An engine is launched by exactly one *_start cycle, and its
// *_done pulse counts only while the controller sits in the matching *_WAIT
// state. At any other time the pulse is dropped without effect.
module warp_iter_ctrl
  import optflow_pkg::*;
#(
  parameter int MAX_ITERS      = DEF_MAX_ITERS,
  parameter int ITER_WIDTH     = DEF_ITER_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int TMR_WIDTH      = DEF_TMR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ITER_WIDTH-1:0] num_iters,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ITER_WIDTH-1:0] iter_count,
  output logic                  buf_sel,
  output logic                  flow_start,
  input  logic                  flow_done,
  output logic                  warp_start,
  input  logic                  warp_done,
  output logic [2:0]            state_dbg
);

  localparam logic [ITER_WIDTH-1:0] MAX_T = ITER_WIDTH'(MAX_ITERS);

  warp_ctrl_state_e      state;
  logic [ITER_WIDTH-1:0] target;
  logic [ITER_WIDTH-1:0] target_req;
  logic [ITER_WIDTH-1:0] iter_next;
  logic                  wd_clr;
  logic                  wd_en;
  logic                  wd_expired;

  assign target_req = (num_iters > MAX_T) ? MAX_T : num_iters;
  assign iter_next  = iter_count + 1'b1;
  assign state_dbg  = state;

  // The watchdog restarts on every launch and runs only while a stage is awaited.
  assign wd_clr = (state == FLOW_GO) || (state == WARP_GO);
  assign wd_en  = (state == FLOW_WAIT) || (state == WARP_WAIT);

  watchdog_timer #(
    .TMR_WIDTH      (TMR_WIDTH),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_expired)
  );

  // The outputs are loaded on the same edge as the state they belong to, so
  // flow_start/warp_start/done are high exactly during FLOW_GO/WARP_GO/FINISH.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      target     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      iter_count <= '0;
      buf_sel    <= 1'b0;
      flow_start <= 1'b0;
      warp_start <= 1'b0;
    end else begin
      done       <= 1'b0;
      flow_start <= 1'b0;
      warp_start <= 1'b0;
      if (abort) begin
        // error, iter_count and buf_sel keep their values for post-mortem.
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              target     <= target_req;
              iter_count <= '0;
              error      <= 1'b0;
              busy       <= 1'b1;
              if (target_req == '0) begin
                state <= FINISH;
                done  <= 1'b1;
              end else begin
                state      <= FLOW_GO;
                flow_start <= 1'b1;
              end
            end
          end
          FLOW_GO: state <= FLOW_WAIT;
          FLOW_WAIT: begin
            // A completion that lands on the expiry cycle still counts.
            if (flow_done) begin
              state      <= WARP_GO;
              warp_start <= 1'b1;
            end else if (wd_expired) begin
              state <= FINISH;
              error <= 1'b1;
              done  <= 1'b1;
            end
          end
          WARP_GO: state <= WARP_WAIT;
          WARP_WAIT: begin
            if (warp_done) begin
              state <= SWAP;
            end else if (wd_expired) begin
              state <= FINISH;
              error <= 1'b1;
              done  <= 1'b1;
            end
          end
          SWAP: begin
            // The freshly written bank becomes the read bank for the next pass.
            buf_sel    <= ~buf_sel;
            iter_count <= iter_next;
            if (iter_next == target) begin
              state <= FINISH;
              done  <= 1'b1;
            end else begin
              state      <= FLOW_GO;
              flow_start <= 1'b1;
            end
          end
          FINISH: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_warp_iter_ctrl.sv
// tb_warp_iter_ctrl
//   Drives warp_iter_ctrl from an open-loop plan. For every run, a timeline
//   model computes the cycle of each flow_start / warp_start / done event from
//   the engine latencies. It also gives the final error, iter_count and buf_sel
//   and the number of busy cycles. The engine done pulses, abort/reset, and
//   spurious pulses are scheduled from that plan. Observed events are matched
//   in order against the expected queue.
module tb_warp_iter_ctrl;
  import optflow_pkg::*;

  localparam int MAX_IT = 8;
  localparam int IW     = 4;
  localparam int TO     = 50;
  localparam int TW     = 20;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic [IW-1:0] num_iters;
  logic          busy;
  logic          done;
  logic          error;
  logic [IW-1:0] iter_count;
  logic          buf_sel;
  logic          flow_start;
  logic          flow_done;
  logic          warp_start;
  logic          warp_done;
  logic [2:0]    state_dbg;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  warp_iter_ctrl #(
    .MAX_ITERS      (MAX_IT),
    .ITER_WIDTH     (IW),
    .TIMEOUT_CYCLES (TO),
    .TMR_WIDTH      (TW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .num_iters  (num_iters),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .iter_count (iter_count),
    .buf_sel    (buf_sel),
    .flow_start (flow_start),
    .flow_done  (flow_done),
    .warp_start (warp_start),
    .warp_done  (warp_done),
    .state_dbg  (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int          n_chk = 0;
  int          n_err = 0;
  int          busy_cnt;
  logic [31:0] exp_q[$];        // {kind[1:0], cycle[29:0]}: 1=flow_start 2=warp_start 3=done
  int          fl_plan[MAX_IT];
  int          wl_plan[MAX_IT];
  bit          fd_s[int];       // cycles at which flow_done is driven
  bit          wd_s[int];       // cycles at which warp_done is driven
  bit          st_s[int];       // extra start pokes while busy
  int          err_m;
  int          ic_m;
  int          buf_m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic chk_ev(input logic [1:0] kind, input string tag);
    logic [31:0] got;
    logic [31:0] exp;
    got = {kind, 30'(cyc)};
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'h0;
    chk(tag, got, exp);
  endtask

  // Samples the registered outputs at the falling edge.
  task automatic mon_step();
    if (flow_start === 1'b1) chk_ev(2'd1, "flow_start_event");
    if (warp_start === 1'b1) chk_ev(2'd2, "warp_start_event");
    if (done === 1'b1)       chk_ev(2'd3, "done_event");
    if (busy === 1'b1)       busy_cnt++;
  endtask

  function automatic int rand_lat();
    int r;
    r = int'($urandom_range(0, 19));
    if (r == 0) return TO + int'($urandom_range(1, 5));  // engine hangs past the watchdog
    if (r == 1) return TO;                                // completes on the expiry cycle
    return int'($urandom_range(1, 12));
  endfunction

  // ---------------- driver + reference model ----------------
  // kmode: 0 none, 1 abort at T+krel, 2 reset at T+krel. krel < 0 picks a random offset.
  task automatic run(input int num, input int kmode, input int krel, input bit spur);
    int T, t, w, s, D, n, e_err, A, end_c, nsw, exp_busy, lim;
    int ev_c[$];
    logic [1:0] ev_k[$];
    int sw_c[$];
    T     = cyc + 2;
    n     = (num > MAX_IT) ? MAX_IT : num;
    e_err = 0;
    t     = T + 1;
    D     = -1;
    for (int i = 0; i < n && D < 0; i++) begin
      ev_c.push_back(t); ev_k.push_back(2'd1);
      fd_s[t + fl_plan[i]] = 1'b1;
      if (spur && fl_plan[i] >= 2) wd_s[t + 1] = 1'b1;     // wrong engine while flow runs
      if (fl_plan[i] > TO) begin
        D = t + TO + 1; e_err = 1;
      end else begin
        w = t + fl_plan[i] + 1;
        ev_c.push_back(w); ev_k.push_back(2'd2);
        wd_s[w + wl_plan[i]] = 1'b1;
        if (spur && wl_plan[i] >= 2) fd_s[w + 1] = 1'b1;   // wrong engine while warp runs
        if (wl_plan[i] > TO) begin
          D = w + TO + 1; e_err = 1;
        end else begin
          s = w + wl_plan[i] + 1;
          sw_c.push_back(s);
          t = s + 1;
        end
      end
    end
    if (D < 0) D = t;
    if (spur) wd_s[T - 1] = 1'b1;                            // stray completion in IDLE

    if (kmode == 0)     A = 1 << 29;
    else if (krel >= 0) A = T + krel;
    else                A = T + int'($urandom_range(0, D - T + 1));

    if (spur) begin
      lim = (D < A) ? D : A;
      if (lim >= T + 1) begin
        repeat (2) st_s[T + 1 + int'($urandom_range(0, lim - T - 1))] = 1'b1;
      end
    end

    foreach (ev_c[i]) if (ev_c[i] <= A) exp_q.push_back({ev_k[i], 30'(ev_c[i])});
    if (D <= A) exp_q.push_back({2'd3, 30'(D)});

    nsw = 0;
    foreach (sw_c[i]) if (sw_c[i] < A) nsw++;
    if (kmode == 2) begin
      err_m = 0; ic_m = 0; buf_m = 0;
    end else if (A > T) begin
      err_m = (D <= A) ? e_err : 0;
      ic_m  = nsw;
      buf_m = buf_m ^ (nsw % 2);
    end
    exp_busy = (A <= T) ? 0 : ((D <= A) ? D - T : A - T);

    end_c = D;
    if (kmode != 0 && A > end_c) end_c = A;
    foreach (fd_s[k]) if (k > end_c) end_c = k;
    foreach (wd_s[k]) if (k > end_c) end_c = k;
    foreach (st_s[k]) if (k > end_c) end_c = k;
    end_c = end_c + 4;

    busy_cnt = 0;
    while (cyc < end_c) begin
      @(negedge clk);
      mon_step();
      start     = (cyc == T) || st_s.exists(cyc);
      num_iters = (cyc == T) ? IW'(num) : IW'($urandom_range(0, 15));
      abort     = (kmode == 1) && (cyc == A);
      rst       = (kmode == 2) && (cyc == A);
      flow_done = fd_s.exists(cyc);
      warp_done = wd_s.exists(cyc);
    end

    chk("missing_events", exp_q.size(), 0);
    exp_q.delete();
    chk("busy_cycles", busy_cnt, exp_busy);
    chk("busy_after_run", busy, 1'b0);
    chk("error", error, err_m);
    chk("iter_count", iter_count, ic_m);
    chk("buf_sel", buf_sel, buf_m);
    chk("state_idle", state_dbg, IDLE);
    fd_s.delete(); wd_s.delete(); st_s.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int kr;
    int km;
    rst = 1'b1; start = 1'b0; abort = 1'b0; flow_done = 1'b0; warp_done = 1'b0; num_iters = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_error", error, 1'b0);
    chk("reset_iter_count", iter_count, 0);
    chk("reset_buf_sel", buf_sel, 1'b0);
    chk("reset_flow_start", flow_start, 1'b0);
    chk("reset_warp_start", warp_start, 1'b0);
    chk("reset_state", state_dbg, IDLE);
    rst = 1'b0;
    @(negedge clk);
    err_m = 0; ic_m = 0; buf_m = 0;

    // Three iterations with 10-cycle engines.
    for (int i = 0; i < MAX_IT; i++) begin fl_plan[i] = 10; wl_plan[i] = 10; end
    run(3, 0, 0, 1'b0);
    // Zero iterations.
    run(0, 0, 0, 1'b0);
    // The request of 15 is clamped to 8 iterations.
    for (int i = 0; i < MAX_IT; i++) begin
      fl_plan[i] = int'($urandom_range(1, 6)); wl_plan[i] = int'($urandom_range(1, 6));
    end
    run(15, 0, 0, 1'b0);
    // warp_done never arrives, so the watchdog ends the run with error.
    fl_plan[0] = 5; wl_plan[0] = TO + 3;
    run(2, 0, 0, 1'b0);
    // Abort in the same cycle as start: the start is not taken and error is held.
    run(1, 1, 0, 1'b0);
    // The next accepted start clears error.
    run(0, 0, 0, 1'b0);
    // Abort in FLOW_WAIT of iteration 2 (flow_start at T+24, abort at T+27).
    for (int i = 0; i < MAX_IT; i++) begin fl_plan[i] = 10; wl_plan[i] = 10; end
    run(3, 1, 27, 1'b0);
    // Stray pulses, start while busy, and completions landing on the expiry cycle.
    fl_plan[0] = 4;  wl_plan[0] = TO;
    fl_plan[1] = 3;  wl_plan[1] = 6;
    fl_plan[2] = TO; wl_plan[2] = 2;
    run(3, 0, 0, 1'b1);
    // Reset partway through a run.
    for (int i = 0; i < MAX_IT; i++) begin fl_plan[i] = 3; wl_plan[i] = 3; end
    run(4, 2, 15, 1'b0);

    // Randomised runs.
    repeat (40) begin
      for (int i = 0; i < MAX_IT; i++) begin fl_plan[i] = rand_lat(); wl_plan[i] = rand_lat(); end
      kr = int'($urandom_range(0, 19));
      km = (kr < 3) ? 1 : ((kr == 3) ? 2 : 0);
      run(int'($urandom_range(0, 15)), km, -1, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL global_timeout: simulation exceeded its time limit at cycle %0d", cyc);
    $fatal(1, "time limit");
  end

endmodule
